// File: rtl/sys_if_cmd_master.sv
// Command-driven initiator for the sys_if register bus: runs WRITE, READ and POLL
// commands one at a time and returns one response per command.
module sys_if_cmd_master #(
  parameter int RD_WAIT      = 1,
  parameter int POLL_GAP     = 4,
  parameter int POLL_TIMEOUT = 1024
) (
  input  logic        sys_if_clk,
  input  logic        sys_if_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [31:0] cmd_mask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_status,
  output logic        busy,
  output logic        sys_if_wen,
  output logic [31:0] sys_if_addr,
  output logic [31:0] sys_if_wdata,
  input  logic [31:0] sys_if_rdata
);

  localparam int WW    = $clog2(RD_WAIT + 1);
  localparam int GW    = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
  localparam int ATT_W = $clog2(POLL_TIMEOUT + 1);

  localparam logic [WW-1:0]    WAIT_LAST = WW'(RD_WAIT - 1);
  localparam logic [GW-1:0]    GAP_LAST  = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
  localparam logic [ATT_W-1:0] ATT_LAST  = ATT_W'(POLL_TIMEOUT - 1);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ILLEGAL = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_WAIT,
    S_POLL_GAP,
    S_RESP
  } state_t;

  state_t            state_q;
  logic              cmd_ready_q, rsp_valid_q, busy_q, wen_q, is_poll_q;
  logic [31:0]       rsp_rdata_q, addr_q, wdata_q, exp_q, mask_q;
  logic [1:0]        rsp_status_q;
  logic [WW-1:0]     wait_q;
  logic [GW-1:0]     gap_q;
  logic [ATT_W-1:0]  att_q, att_d;
  logic              hit;

  function automatic logic poll_match(input logic [31:0] sample, input logic [31:0] expv,
                                      input logic [31:0] mask);
    return ((sample ^ expv) & mask) == 32'h0;
  endfunction

  assign att_d = att_q + 1'b1;
  assign hit   = poll_match(sys_if_rdata, exp_q, mask_q);

  always_ff @(posedge sys_if_clk or posedge sys_if_rst) begin
    if (sys_if_rst) begin
      state_q      <= S_IDLE;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= ST_OK;
      busy_q       <= 1'b0;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      exp_q        <= '0;
      mask_q       <= '0;
      is_poll_q    <= 1'b0;
      wait_q       <= '0;
      gap_q        <= '0;
      att_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            exp_q       <= cmd_wdata;
            mask_q      <= cmd_mask;
            wait_q      <= '0;
            gap_q       <= '0;
            att_q       <= '0;
            is_poll_q   <= (cmd_op == OP_POLL);
            if (cmd_op == OP_WRITE || cmd_op == OP_READ || cmd_op == OP_POLL) begin
              addr_q  <= cmd_addr;
              wdata_q <= cmd_wdata;
            end
            case (cmd_op)
              OP_WRITE: begin
                wen_q   <= 1'b1;
                state_q <= S_WRITE;
              end
              OP_READ, OP_POLL: state_q <= S_RD_WAIT;
              default: begin
                // Illegal op answers immediately and never touches the bus.
                rsp_valid_q  <= 1'b1;
                rsp_rdata_q  <= '0;
                rsp_status_q <= ST_ILLEGAL;
                state_q      <= S_RESP;
              end
            endcase
          end
        end
        S_WRITE: begin
          wen_q        <= 1'b0;
          rsp_valid_q  <= 1'b1;
          rsp_rdata_q  <= '0;
          rsp_status_q <= ST_OK;
          state_q      <= S_RESP;
        end
        S_RD_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            wait_q      <= '0;
            rsp_rdata_q <= sys_if_rdata;
            if (!is_poll_q || hit) begin
              att_q        <= att_d;
              rsp_valid_q  <= 1'b1;
              rsp_status_q <= ST_OK;
              state_q      <= S_RESP;
            end else if (att_q == ATT_LAST) begin
              att_q        <= att_d;
              rsp_valid_q  <= 1'b1;
              rsp_status_q <= ST_TIMEOUT;
              state_q      <= S_RESP;
            end else begin
              att_q   <= att_d;
              state_q <= (POLL_GAP == 0) ? S_RD_WAIT : S_POLL_GAP;
            end
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_POLL_GAP: begin
          if (gap_q == GAP_LAST) begin
            gap_q   <= '0;
            state_q <= S_RD_WAIT;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_status   = rsp_status_q;
  assign busy         = busy_q;
  assign sys_if_wen   = wen_q;
  assign sys_if_addr  = addr_q;
  assign sys_if_wdata = wdata_q;

endmodule

// File: tb/tb_sys_if_cmd_master.sv
// Bench for sys_if_cmd_master: small register slave plus a command-level reference model.
module tb_sys_if_cmd_master;
  localparam int RD_WAIT      = 1;
  localparam int POLL_GAP     = 4;
  localparam int POLL_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0, cmd_mask = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;
  logic        busy;
  logic        sys_if_wen;
  logic [31:0] sys_if_addr, sys_if_wdata, sys_if_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sys_if_cmd_master #(.RD_WAIT(RD_WAIT), .POLL_GAP(POLL_GAP), .POLL_TIMEOUT(POLL_TIMEOUT)) dut (
    .sys_if_clk(clk), .sys_if_rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
    .busy(busy), .sys_if_wen(sys_if_wen), .sys_if_addr(sys_if_addr), .sys_if_wdata(sys_if_wdata),
    .sys_if_rdata(sys_if_rdata)
  );

  // Register slave: 16 words, 0x14 is a read-only NUM_CHANNEL=4 register.
  logic [31:0] mem [0:15];
  logic        poke_en = 1'b0;
  logic [31:0] poke_addr = '0, poke_val = '0;
  always @(posedge clk) begin
    if (sys_if_wen && sys_if_addr != 32'h14) mem[sys_if_addr[5:2]] <= sys_if_wdata;
    if (poke_en) mem[poke_addr[5:2]] <= poke_val;
  end
  assign sys_if_rdata = (sys_if_addr == 32'h14) ? 32'd4 : mem[sys_if_addr[5:2]];

  // Reference model state
  logic [31:0] ref_mem [0:15];
  logic [31:0] last_addr = '0;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return (a == 32'h14) ? 32'd4 : ref_mem[a[5:2]];
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input int attempts);
    case (op)
      2'b00:   return 2;
      2'b01:   return RD_WAIT + 1;
      2'b10:   return 1 + attempts * RD_WAIT + (attempts - 1) * POLL_GAP;
      default: return 1;
    endcase
  endfunction

  task automatic poke(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_val = v;
    @(negedge clk);
    poke_en = 1'b0;
    ref_mem[a[5:2]] = v;
  endtask

  // Drives one command and collects what the DUT did; the test tasks judge it.
  task automatic run_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] mask, input int hold, input int chg_at,
                         input logic [31:0] chg_val, output int lat, output logic [31:0] rdata,
                         output logic [1:0] status, output int wens, output bit stable,
                         output bit proto);
    int w;
    bit got;
    proto = 1; stable = 1; wens = 0; lat = -1; rdata = 'x; status = 'x;
    @(negedge clk);
    w = 0;
    while (cmd_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    if (cmd_ready !== 1'b1) proto = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wdata; cmd_mask = mask;
    @(posedge clk);
    #1;
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_op = 2'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom; cmd_mask = $urandom;
    got = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      poke_en = 1'b0;
      if (sys_if_wen === 1'b1) wens++;
      if (rsp_valid === 1'b1) begin
        got = 1; lat = k + 1; rdata = rsp_rdata; status = rsp_status;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) stable = 0;
      end else if (k == chg_at) begin
        poke_en = 1'b1; poke_addr = 32'h10; poke_val = chg_val;
      end
    end
    poke_en = 1'b0;
    cmd_valid = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (sys_if_wen === 1'b1) wens++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== rdata || rsp_status !== status ||
          cmd_ready !== 1'b0 || busy !== 1'b1) stable = 0;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    if (sys_if_wen === 1'b1) wens++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) proto = 0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 16; i++) poke(32'(i * 4), $urandom);
    @(negedge clk);
    n_tests++;
    if ({cmd_ready, rsp_valid, busy, sys_if_wen} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl got %b required 0000", {cmd_ready, rsp_valid, busy, sys_if_wen});
    end
    n_tests++;
    if ({sys_if_addr, sys_if_wdata, rsp_rdata, rsp_status} !== 98'h0) begin
      n_fail++; $display("FAIL reset_data got addr=%h wdata=%h rdata=%h st=%0d required all 0",
                         sys_if_addr, sys_if_wdata, rsp_rdata, rsp_status);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release got ready=%b busy=%b required 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_write_read;
    int lat, wens; logic [31:0] rd; logic [1:0] st; bit stb, pr;
    run_cmd(2'b00, 32'h10, 32'hA5A5_0001, 32'h0, 0, -1, 32'h0, lat, rd, st, wens, stb, pr);
    ref_mem[4] = 32'hA5A5_0001;
    n_tests++;
    if ({lat, wens, rd, st} !== {32'd2, 32'd1, 32'h0, 2'b00}) begin
      n_fail++; $display("FAIL write got lat=%0d wens=%0d rdata=%h st=%0d required 2 1 0 0", lat, wens, rd, st);
    end
    n_tests++;
    if (sys_if_addr !== 32'h10 || sys_if_wdata !== 32'hA5A5_0001 || !pr || !stb) begin
      n_fail++; $display("FAIL write_bus got addr=%h wdata=%h proto=%0d required 10 a5a50001 1",
                         sys_if_addr, sys_if_wdata, pr);
    end
    run_cmd(2'b01, 32'h10, 32'h0, 32'h0, 0, -1, 32'h0, lat, rd, st, wens, stb, pr);
    n_tests++;
    if ({lat, wens, rd, st} !== {exp_lat(2'b01, 1), 32'd0, ref_rd(32'h10), 2'b00}) begin
      n_fail++; $display("FAIL readback got lat=%0d wens=%0d rdata=%h st=%0d required %0d 0 %h 0",
                         lat, wens, rd, st, exp_lat(2'b01, 1), ref_rd(32'h10));
    end
  endtask

  task automatic test_read_const;
    int lat, wens; logic [31:0] rd; logic [1:0] st; bit stb, pr;
    run_cmd(2'b01, 32'h14, 32'h0, 32'h0, 0, -1, 32'h0, lat, rd, st, wens, stb, pr);
    n_tests++;
    if ({lat, wens, rd, st} !== {32'd2, 32'd0, 32'h4, 2'b00} || !pr) begin
      n_fail++; $display("FAIL read_nch got lat=%0d wens=%0d rdata=%h st=%0d required 2 0 4 0", lat, wens, rd, st);
    end
  endtask

  task automatic test_poll;
    int lat, wens; logic [31:0] rd; logic [1:0] st; bit stb, pr;
    poke(32'h10, 32'h1234_5601);
    run_cmd(2'b10, 32'h10, 32'h01, 32'hFF, 0, -1, 32'h0, lat, rd, st, wens, stb, pr);
    n_tests++;
    if ({lat, rd, st} !== {exp_lat(2'b10, 1), 32'h1234_5601, 2'b00} || wens != 0) begin
      n_fail++; $display("FAIL poll_first got lat=%0d rdata=%h st=%0d required %0d 12345601 0",
                         lat, rd, st, exp_lat(2'b10, 1));
    end
    poke(32'h10, 32'h1234_5600);
    // Scratch flips between the second and third sample.
    run_cmd(2'b10, 32'h10, 32'h01, 32'hFF, 0, 7, 32'h1234_5601, lat, rd, st, wens, stb, pr);
    ref_mem[4] = 32'h1234_5601;
    n_tests++;
    if ({lat, rd, st} !== {exp_lat(2'b10, 3), 32'h1234_5601, 2'b00}) begin
      n_fail++; $display("FAIL poll_third got lat=%0d rdata=%h st=%0d required %0d 12345601 0",
                         lat, rd, st, exp_lat(2'b10, 3));
    end
    run_cmd(2'b10, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, -1, 32'h0, lat, rd, st, wens, stb, pr);
    n_tests++;
    if ({lat, st} !== {exp_lat(2'b10, 1), 2'b00}) begin
      n_fail++; $display("FAIL poll_mask0 got lat=%0d st=%0d required %0d 0", lat, st, exp_lat(2'b10, 1));
    end
  endtask

  task automatic test_poll_timeout;
    int lat, wens; logic [31:0] rd; logic [1:0] st; bit stb, pr;
    run_cmd(2'b10, 32'h10, 32'h02, 32'hFF, 0, -1, 32'h0, lat, rd, st, wens, stb, pr);
    n_tests++;
    if ({lat, rd, st} !== {32'd37, ref_rd(32'h10), 2'b01} || wens != 0 || !pr) begin
      n_fail++; $display("FAIL poll_timeout got lat=%0d rdata=%h st=%0d required 37 %h 1",
                         lat, rd, st, ref_rd(32'h10));
    end
  endtask

  task automatic test_backpressure_illegal;
    int lat, wens; logic [31:0] rd; logic [1:0] st; bit stb, pr;
    run_cmd(2'b01, 32'h10, 32'h0, 32'h0, 10, -1, 32'h0, lat, rd, st, wens, stb, pr);
    n_tests++;
    if (!stb || !pr || rd !== ref_rd(32'h10)) begin
      n_fail++; $display("FAIL backpressure got stable=%0d proto=%0d rdata=%h required 1 1 %h",
                         stb, pr, rd, ref_rd(32'h10));
    end
    run_cmd(2'b11, 32'h30, 32'h1111_2222, 32'h0, 0, -1, 32'h0, lat, rd, st, wens, stb, pr);
    n_tests++;
    if ({lat, wens, rd, st} !== {32'd1, 32'd0, 32'h0, 2'b10}) begin
      n_fail++; $display("FAIL illegal got lat=%0d wens=%0d rdata=%h st=%0d required 1 0 0 2", lat, wens, rd, st);
    end
    n_tests++;
    if (sys_if_addr !== 32'h10) begin
      n_fail++; $display("FAIL illegal_addr got %h required 10", sys_if_addr);
    end
    last_addr = 32'h10;
  endtask

  task automatic test_random;
    int lat, wens, r, b, n, el, ew; logic [31:0] rd, a, d, m, v, e, er; logic [1:0] st, op, es;
    bit stb, pr, matched;
    for (int it = 0; it < 30; it++) begin
      r  = $urandom_range(0, 9);
      op = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      a  = 32'($urandom_range(0, 15)) << 2;
      d  = $urandom;
      m  = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      v  = ref_rd(a);
      e  = d;
      matched = 1;
      if (op == 2'b10) begin
        e = (v & m) | ($urandom & ~m);
        if (m != 0 && $urandom_range(0, 1) == 1) begin
          do b = $urandom_range(0, 31); while (!m[b]);
          e[b] = ~e[b];
          matched = 0;
        end
      end
      run_cmd(op, a, e, m, $urandom_range(0, 3), -1, 32'h0, lat, rd, st, wens, stb, pr);
      n = matched ? 1 : POLL_TIMEOUT;
      el = exp_lat(op, n); ew = 0; er = 32'h0; es = 2'b00;
      case (op)
        2'b00: begin ew = 1; if (a != 32'h14) ref_mem[a[5:2]] = e; last_addr = a; end
        2'b01: begin er = v; last_addr = a; end
        2'b10: begin er = v; es = matched ? 2'b00 : 2'b01; last_addr = a; end
        default: es = 2'b10;
      endcase
      n_tests++;
      if ({lat, wens, rd, st} !== {el, ew, er, es}) begin
        n_fail++; $display("FAIL rand[%0d] op=%0d got lat=%0d wens=%0d rdata=%h st=%0d required %0d %0d %h %0d",
                           it, op, lat, wens, rd, st, el, ew, er, es);
      end
      n_tests++;
      if (!stb || !pr || sys_if_addr !== last_addr) begin
        n_fail++; $display("FAIL rand_hs[%0d] got stable=%0d proto=%0d addr=%h required 1 1 %h",
                           it, stb, pr, sys_if_addr, last_addr);
      end
    end
  endtask

  task automatic test_reset_mid;
    int lat, wens; logic [31:0] rd, v; logic [1:0] st; bit stb, pr, saw;
    // Reset while waiting in the poll gap.
    v = ref_mem[4];
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 32'h10; cmd_wdata = ~v; cmd_mask = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_tests++;
    if ({cmd_ready, rsp_valid, busy, sys_if_wen, sys_if_addr, sys_if_wdata} !== 68'h0) begin
      n_fail++; $display("FAIL rst_gap got ready=%b valid=%b busy=%b wen=%b addr=%h required all 0",
                         cmd_ready, rsp_valid, busy, sys_if_wen, sys_if_addr);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    saw = 0;
    for (int i = 0; i < 60; i++) begin @(negedge clk); if (rsp_valid !== 1'b0) saw = 1; end
    n_tests++;
    if (saw || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_gap_after got rsp_seen=%0d ready=%b required 0 1", saw, cmd_ready);
    end
    // Reset during the write strobe cycle.
    v = ref_mem[8];
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 32'h20; cmd_wdata = ~v; cmd_mask = 32'h0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n_tests++;
    if (sys_if_wen !== 1'b1) begin
      n_fail++; $display("FAIL rst_wr_strobe got wen=%b required 1", sys_if_wen);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({sys_if_wen, busy, cmd_ready, sys_if_addr} !== 35'h0) begin
      n_fail++; $display("FAIL rst_wr got wen=%b busy=%b ready=%b addr=%h required all 0",
                         sys_if_wen, busy, cmd_ready, sys_if_addr);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    run_cmd(2'b01, 32'h20, 32'h0, 32'h0, 0, -1, 32'h0, lat, rd, st, wens, stb, pr);
    n_tests++;
    if (rd !== v || st !== 2'b00 || !pr) begin
      n_fail++; $display("FAIL rst_wr_nowrite got rdata=%h st=%0d required %h 0", rd, st, v);
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_read_const;
    test_poll;
    test_poll_timeout;
    test_backpressure_illegal;
    test_random;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit expired");
    $fatal(1, "watchdog");
  end

endmodule
